// File: rtl/line_mem_arbiter_pkg.sv
// Shared encodings and defaults for the line memory arbiter.
// Used by the interface and the top; the ARB_ROUND_ROBIN_EN macro is consumed only in the top.
package line_mem_arbiter_pkg;

  localparam int LINE_BITS_DEF = 256;
  localparam int ADDR_BITS_DEF = 32;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_GRANT_I = 2'd1,
    ARB_GRANT_D = 2'd2
  } arb_state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage

// File: rtl/line_mem_arbiter_if.sv
// Bundle of icache, dcache and memory line-port signals around the arbiter.
// slave is the arbiter's view; master is the surrounding caches and memory.
interface line_mem_arbiter_if #(
  parameter int LINE_BITS = line_mem_arbiter_pkg::LINE_BITS_DEF,
  parameter int ADDR_BITS = line_mem_arbiter_pkg::ADDR_BITS_DEF
);

  logic [ADDR_BITS-1:0] i_addr_i;
  logic                 i_rd_i;
  logic [LINE_BITS-1:0] i_data_o;
  logic                 i_ack_o;
  logic                 i_page_fault_o;

  logic [ADDR_BITS-1:0] d_addr_i;
  logic [LINE_BITS-1:0] d_data_i;
  logic                 d_rd_i;
  logic                 d_wr_i;
  logic [LINE_BITS-1:0] d_data_o;
  logic                 d_ack_o;
  logic                 d_page_fault_o;

  logic [ADDR_BITS-1:0] mem_addr_o;
  logic [LINE_BITS-1:0] mem_data_o;
  logic                 mem_rd_o;
  logic                 mem_wr_o;
  logic [LINE_BITS-1:0] mem_data_i;
  logic                 mem_ack_i;
  logic                 mem_page_fault_i;

  modport slave (
    input  i_addr_i, i_rd_i, d_addr_i, d_data_i, d_rd_i, d_wr_i,
           mem_data_i, mem_ack_i, mem_page_fault_i,
    output i_data_o, i_ack_o, i_page_fault_o, d_data_o, d_ack_o, d_page_fault_o,
           mem_addr_o, mem_data_o, mem_rd_o, mem_wr_o
  );

  modport master (
    output i_addr_i, i_rd_i, d_addr_i, d_data_i, d_rd_i, d_wr_i,
           mem_data_i, mem_ack_i, mem_page_fault_i,
    input  i_data_o, i_ack_o, i_page_fault_o, d_data_o, d_ack_o, d_page_fault_o,
           mem_addr_o, mem_data_o, mem_rd_o, mem_wr_o
  );

endinterface

// File: rtl/line_mem_arbiter.sv
// Arbitrates the single line memory port between icache refill and dcache refill/writeback.
// Define ARB_ROUND_ROBIN_EN to alternate grants on simultaneous requests (default: dcache first).
module line_mem_arbiter
  import line_mem_arbiter_pkg::*;
#(
  parameter int LINE_BITS = LINE_BITS_DEF,
  parameter int ADDR_BITS = ADDR_BITS_DEF
) (
  input logic               clk,
  input logic               rst,
  line_mem_arbiter_if.slave bus
);

  arb_state_e state_q, state_d;
  logic       last_grant_q, last_grant_d;
  logic       i_req, d_req;

  assign i_req = bus.i_rd_i;
  assign d_req = bus.d_rd_i | bus.d_wr_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= GRANT_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Grants are only issued from IDLE, so every ack is followed by at least one IDLE cycle.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    case (state_q)
      ARB_IDLE: begin
        if (i_req && d_req) begin
`ifdef ARB_ROUND_ROBIN_EN
          state_d = (last_grant_q == GRANT_D) ? ARB_GRANT_I : ARB_GRANT_D;
`else
          state_d = ARB_GRANT_D;
`endif
        end else if (d_req) begin
          state_d = ARB_GRANT_D;
        end else if (i_req) begin
          state_d = ARB_GRANT_I;
        end
      end
      ARB_GRANT_I: begin
        if (bus.mem_ack_i) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_I;
        end
      end
      ARB_GRANT_D: begin
        if (bus.mem_ack_i) begin
          state_d      = ARB_IDLE;
          last_grant_d = GRANT_D;
        end
      end
      default: state_d = ARB_IDLE;
    endcase
  end

`ifndef ARB_ROUND_ROBIN_EN
  // Kept for the round-robin build; no decision depends on it here.
  logic unused_last_grant;
  assign unused_last_grant = last_grant_q;
`endif

  // Output steering: only the granted side sees memory data, ack and fault.
  always_comb begin
    bus.mem_addr_o     = {ADDR_BITS{1'b0}};
    bus.mem_data_o     = {LINE_BITS{1'b0}};
    bus.mem_rd_o       = 1'b0;
    bus.mem_wr_o       = 1'b0;
    bus.i_data_o       = {LINE_BITS{1'b0}};
    bus.i_ack_o        = 1'b0;
    bus.i_page_fault_o = 1'b0;
    bus.d_data_o       = {LINE_BITS{1'b0}};
    bus.d_ack_o        = 1'b0;
    bus.d_page_fault_o = 1'b0;
    case (state_q)
      ARB_GRANT_I: begin
        bus.mem_addr_o     = bus.i_addr_i;
        bus.mem_rd_o       = 1'b1;
        bus.i_data_o       = bus.mem_data_i;
        bus.i_ack_o        = bus.mem_ack_i;
        bus.i_page_fault_o = bus.mem_page_fault_i & bus.mem_ack_i;
      end
      ARB_GRANT_D: begin
        bus.mem_addr_o     = bus.d_addr_i;
        bus.mem_data_o     = bus.d_data_i;
        bus.mem_rd_o       = bus.d_rd_i;
        bus.mem_wr_o       = bus.d_wr_i;
        bus.d_data_o       = bus.mem_data_i;
        bus.d_ack_o        = bus.mem_ack_i;
        bus.d_page_fault_o = bus.mem_page_fault_i & bus.mem_ack_i;
      end
      default: ;
    endcase
  end

endmodule
